// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the IF/ID/EX/MEM register chain: per-stage enables and flushes from
// load-use, taken-branch, memory-busy and halt conditions, plus a saturating stall counter.
module pipe_hazard_ctrl #(
   parameter int unsigned REGFILE_ADDR_WIDTH = 5,
   parameter int unsigned DRAIN_CYCLES       = 3,
   parameter int unsigned CNT_WIDTH          = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic                          halt_req,
   input  logic                          mem_busy,
   input  logic                          branch_taken,
   input  logic [REGFILE_ADDR_WIDTH-1:0] id_rs1_addr,
   input  logic [REGFILE_ADDR_WIDTH-1:0] id_rs2_addr,
   input  logic [REGFILE_ADDR_WIDTH-1:0] ex_wr_addr,
   input  logic                          ex_wr_en,
   input  logic                          ex_mem_read,
   output logic                          pc_en,
   output logic                          if_id_en,
   output logic                          id_ex_en,
   output logic                          ex_mem_en,
   output logic                          if_id_flush,
   output logic                          id_ex_flush,
   output logic                          halted,
   output logic [CNT_WIDTH-1:0]          stall_cycles
);

   localparam int unsigned DcW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DcW-1:0] DrainInit = DcW'(DRAIN_CYCLES - 1);

   typedef enum logic [2:0] {StIdle, StRun, StMemWait, StDrain, StHalted} state_e;

   state_e               state_q, state_d;
   logic [DcW-1:0]       drain_cnt_q, drain_cnt_d;
   logic                 halted_q, halted_d;
   logic [CNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;
   logic                 load_use;
   logic                 stall_inc;

   assign load_use = ex_mem_read && ex_wr_en && (ex_wr_addr != '0) &&
                     ((ex_wr_addr == id_rs1_addr) || (ex_wr_addr == id_rs2_addr));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= StIdle;
         drain_cnt_q    <= '0;
         halted_q       <= 1'b0;
         stall_cycles_q <= '0;
      end else begin
         state_q        <= state_d;
         drain_cnt_q    <= drain_cnt_d;
         halted_q       <= halted_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      case (state_q)
         StIdle: if (start) state_d = StRun;
         StRun: begin
            if (mem_busy) begin
               state_d = StMemWait;
            end else if (!branch_taken && !load_use && halt_req) begin
               drain_cnt_d = DrainInit;
               state_d     = (DRAIN_CYCLES == 1) ? StHalted : StDrain;
            end
         end
         StMemWait: if (!mem_busy) state_d = StRun;
         StDrain: begin
            if (!mem_busy) begin
               if (drain_cnt_q == '0) state_d = StHalted;
               else                   drain_cnt_d = drain_cnt_q - DcW'(1);
            end
         end
         StHalted: if (start) state_d = StRun;
         default: state_d = StIdle;
      endcase
   end

   // Frozen-pipe cycles count whether they are the RUN cycle that sees mem_busy or MEMWAIT.
   always_comb begin
      stall_inc = ((state_q == StRun) && (mem_busy || (!branch_taken && load_use))) ||
                  ((state_q == StMemWait) && mem_busy);
      stall_cycles_d = stall_cycles_q;
      if (stall_inc && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + CNT_WIDTH'(1);
      halted_d = (state_d == StHalted);
   end

   always_comb begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      ex_mem_en   = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      case (state_q)
         StRun: begin
            if (!mem_busy) begin
               if (branch_taken) begin
                  pc_en       = 1'b1;
                  if_id_en    = 1'b1;
                  id_ex_en    = 1'b1;
                  ex_mem_en   = 1'b1;
                  if_id_flush = 1'b1;
                  id_ex_flush = 1'b1;
               end else if (load_use) begin
                  id_ex_en    = 1'b1;
                  id_ex_flush = 1'b1;
                  ex_mem_en   = 1'b1;
               end else if (halt_req) begin
                  if_id_en    = 1'b1;
                  id_ex_en    = 1'b1;
                  ex_mem_en   = 1'b1;
                  if_id_flush = 1'b1;
               end else begin
                  pc_en     = 1'b1;
                  if_id_en  = 1'b1;
                  id_ex_en  = 1'b1;
                  ex_mem_en = 1'b1;
               end
            end
         end
         StDrain: begin
            if (!mem_busy) begin
               if_id_en    = 1'b1;
               id_ex_en    = 1'b1;
               ex_mem_en   = 1'b1;
               if_id_flush = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign halted       = halted_q;
   assign stall_cycles = stall_cycles_q;

endmodule
